xgmii_rx_monitor: RTL and testbench
===================================

XGMII_RX_MONITOR -- requirements
Module: xgmii_rx_monitor

Interface
REQ-001 The block SHALL take parameter MIN_LEN, default 64, as the minimum good frame length in octets (DA through FCS).
REQ-002 The block SHALL take parameter ACT_BITS, default 20, as the width of the activity-stretch counter.
REQ-003 The block SHALL have port clk156, input, 1 bit: the 156.25 MHz XGMII clock; it is the only clock.
REQ-004 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port xgmii_rxd, input, 64 bits: receive data, lane n = bits [8n+7:8n].
REQ-006 The block SHALL have port xgmii_rxc, input, 8 bits: receive control, bit n for lane n.
REQ-007 The block SHALL have port xgmii_txd, output, 64 bits: registered copy of xgmii_rxd.
REQ-008 The block SHALL have port xgmii_txc, output, 8 bits: registered copy of xgmii_rxc.
REQ-009 The block SHALL have port stats_clear, input, 1 bit: synchronous clear of all counters.
REQ-010 The block SHALL have port frame_count, output, 32 bits: number of good frames.
REQ-011 The block SHALL have port error_count, output, 32 bits: number of bad frames.
REQ-012 The block SHALL have port len_valid, output, 1 bit: one-cycle pulse when a frame closes.
REQ-013 The block SHALL have port len_value, output, 16 bits: length of the closed frame; valid only while len_valid is high.
REQ-014 The block SHALL have port activity, output, 1 bit: stretched frame-activity indication for an LED.

Function
REQ-015 Pass-through: xgmii_txd and xgmii_txc SHALL equal xgmii_rxd and xgmii_rxc delayed by exactly 1 cycle, with no modification.
REQ-016 Decode:
- Start = lane 0 or lane 4 with control bit set and byte 0xFB.
- Terminate = any lane with control bit set and byte 0xFD.
- Error = any lane with control bit set and byte 0xFE, or any other control byte inside a frame, excluding 0xFD and 0x07 after the terminate lane.
REQ-017 The FSM SHALL have two states, IDLE and FRAME. IDLE goes to FRAME on a start. FRAME goes to IDLE on a terminate.
REQ-018 The raw octet count of a frame SHALL be the number of data lanes (control bit clear) from the lane after start up to the lane before terminate, inclusive.
REQ-019 The frame length SHALL be the raw octet count minus 7 (preamble plus SFD), floored at 0.
REQ-020 The length accumulator SHALL be 16 bits and saturate at 0xFFFF.
REQ-021 A frame SHALL be good when it reaches terminate with no error lane and a length of at least MIN_LEN; every other closed frame is bad.
REQ-022 On close, len_valid SHALL pulse high in the cycle after the terminate word, and the matching counter SHALL increment in the same cycle.
REQ-023 A start while in FRAME SHALL close the current frame as bad and open a new frame in the same cycle.
REQ-024 A terminate in lanes 0–3 together with a start in lane 4 of the same word SHALL close the current frame and then open a new one; the new frame's raw count starts from lanes 5–7.
REQ-025 A start received while in IDLE with an error lane in the same word SHALL still open the frame, and that frame SHALL be marked bad.
REQ-026 frame_count and error_count SHALL saturate at 0xFFFFFFFF.
REQ-027 When stats_clear and an increment occur in the same cycle, the clear SHALL win and the counter SHALL read 0 in the next cycle.
REQ-028 activity: every close SHALL reload a stretch counter to all-ones, the counter SHALL decrement to 0, and activity SHALL be high while the counter is nonzero.

Reset
REQ-029 On sys_rst_n low, regardless of the clock, the block SHALL:
- enter IDLE;
- set all counters, the accumulator and the stretch counter to 0;
- drive len_valid = 0, len_value = 0, activity = 0;
- drive xgmii_txd = 64'h0707070707070707 and xgmii_txc = 8'hFF (idle).
REQ-030 Reset asserted mid-frame SHALL discard the open frame with no counter increment.
REQ-031 Reset deassertion SHALL be synchronised to clk156 before it is used by the FSM.

Structure
REQ-032 The control characters 0xFB, 0xFD, 0xFE and 0x07, the idle word, and the state encoding SHALL be placed in the shared package tap_xgmii_pkg.
REQ-033 The per-word lane decode SHALL be a combinational sub-module, xgmii_lane_decode, producing three outputs:
- a start-lane indication;
- the terminate position (one-hot over 8 lanes);
- a per-lane error mask.

Verification
REQ-034 Idle words only, then one 64-octet frame (start in lane 0) -> frame_count = 1, len_value = 64, one len_valid pulse, error_count = 0.
REQ-035 A 60-octet frame -> error_count = 1, len_value = 60, frame_count unchanged.
REQ-036 A 100-octet frame with 0xFE/ctrl in lane 3 of its third word -> error_count = 1, frame_count = 0.
REQ-037 A terminate in lane 2 and a start in lane 4 in one word, followed by a 64-octet frame -> two len_valid pulses in consecutive frames and frame_count = 2.
REQ-038 A start mid-frame, and separately sys_rst_n pulsed mid-frame:
- start mid-frame -> error_count += 1 and the new frame is counted normally;
- reset mid-frame -> all counters 0 and txd/txc idle.
REQ-039 Every cycle, txd/txc SHALL equal rxd/rxc of the previous cycle; stats_clear asserted on the same cycle as a good close -> frame_count = 0 in the next cycle.

Source files
------------

// File: rtl/tap_xgmii_pkg.sv
// Shared XGMII definitions: control characters, idle word and receive-monitor
// state encoding.
package tap_xgmii_pkg;

  localparam logic [7:0]  CH_START  = 8'hFB;
  localparam logic [7:0]  CH_TERM   = 8'hFD;
  localparam logic [7:0]  CH_ERROR  = 8'hFE;
  localparam logic [7:0]  CH_IDLE   = 8'h07;
  localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_CTRL = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } rx_state_e;

  // Raw data-lane count includes the 7 preamble/SFD octets after the start lane.
  function automatic logic [15:0] frame_len(input logic [15:0] raw);
    return (raw > 16'd7) ? (raw - 16'd7) : '0;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/xgmii_lane_decode.sv
// Combinational per-word XGMII lane decode: start lane, first terminate lane,
// and control lanes that are illegal if they fall inside a frame.
module xgmii_lane_decode
  import tap_xgmii_pkg::*;
(
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic [1:0]  start_lane,
  output logic [7:0]  term_oh,
  output logic [7:0]  err_mask
);

  logic term_found;

  always_comb begin
    start_lane[0] = rxc[0] && (rxd[7:0]   == CH_START);
    start_lane[1] = rxc[4] && (rxd[39:32] == CH_START);

    term_oh    = '0;
    term_found = 1'b0;
    for (int unsigned n = 0; n < 8; n++) begin
      if (!term_found && rxc[n] && (rxd[8*n +: 8] == CH_TERM)) begin
        term_oh[n] = 1'b1;
        term_found = 1'b1;
      end
    end

    // Any control lane other than a legal start or the first terminate
    // (so 0xFE, idles, misplaced 0xFB, a second 0xFD).
    err_mask = rxc & ~term_oh;
    if (start_lane[0]) err_mask[0] = 1'b0;
    if (start_lane[1]) err_mask[4] = 1'b0;
  end

endmodule

// File: rtl/xgmii_rx_monitor.sv
// XGMII receive tap: registered pass-through plus frame length / good / bad
// statistics and a stretched activity indication.
module xgmii_rx_monitor
  import tap_xgmii_pkg::*;
#(
  parameter int unsigned MIN_LEN  = 64,
  parameter int unsigned ACT_BITS = 20
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  input  logic        stats_clear,
  output logic [31:0] frame_count,
  output logic [31:0] error_count,
  output logic        len_valid,
  output logic [15:0] len_value,
  output logic        activity
);

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

  logic [1:0]  rst_sync;
  logic        rst_n;

  rx_state_e   state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        err_q, err_d;
  logic        in_frame;
  logic        close_now, close_good;
  logic [15:0] close_len;

  logic [1:0]  start_lane;
  logic [7:0]  term_oh;
  logic [7:0]  err_mask;

  logic [ACT_BITS-1:0] act_cnt;

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  xgmii_lane_decode u_decode (
    .rxd       (xgmii_rxd),
    .rxc       (xgmii_rxc),
    .start_lane(start_lane),
    .term_oh   (term_oh),
    .err_mask  (err_mask)
  );

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      xgmii_txd <= IDLE_WORD;
      xgmii_txc <= IDLE_CTRL;
    end else begin
      xgmii_txd <= xgmii_rxd;
      xgmii_txc <= xgmii_rxc;
    end
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Lanes are walked in order so a terminate and a following lane-4 start in
  // the same word close one frame and open the next. Only the first close in
  // a word is reported; a frame reopened after it stays open.
  always_comb begin
    in_frame   = (state_q == ST_FRAME);
    acc_d      = acc_q;
    err_d      = err_q;
    close_now  = 1'b0;
    close_good = 1'b0;
    close_len  = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      if (((n == 0) && start_lane[0]) || ((n == 4) && start_lane[1])) begin
        if (in_frame && !close_now) begin
          close_now  = 1'b1;
          close_len  = frame_len(acc_d);
          close_good = 1'b0;
        end
        in_frame = 1'b1;
        acc_d    = '0;
        err_d    = 1'b0;
      end else if (in_frame && term_oh[n]) begin
        if (!close_now) begin
          close_now  = 1'b1;
          close_len  = frame_len(acc_d);
          close_good = !err_d && (frame_len(acc_d) >= MIN_LEN_W);
        end
        in_frame = 1'b0;
      end else if (in_frame) begin
        if (err_mask[n]) err_d = 1'b1;
        else             acc_d = sat_inc16(acc_d);
      end
    end
    state_d = in_frame ? ST_FRAME : ST_IDLE;
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      len_valid <= 1'b0;
      len_value <= '0;
    end else begin
      len_valid <= close_now;
      len_value <= close_now ? close_len : '0;
    end
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
      error_count <= '0;
    end else if (stats_clear) begin
      frame_count <= '0;
      error_count <= '0;
    end else if (close_now) begin
      if (close_good && (frame_count != '1)) frame_count <= frame_count + 32'd1;
      if (!close_good && (error_count != '1)) error_count <= error_count + 32'd1;
    end
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n)              act_cnt <= '0;
    else if (close_now)      act_cnt <= '1;
    else if (act_cnt != '0)  act_cnt <= act_cnt - 1'b1;
  end

  assign activity = (act_cnt != '0);

endmodule

// File: tb/tb_xgmii_rx_monitor.sv
// Directed bench for xgmii_rx_monitor: frames are built octet by octet,
// packed into XGMII words, and results checked against hand-computed values.
module tb_xgmii_rx_monitor;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;

  logic        clk156;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        stats_clear;
  logic [31:0] frame_count;
  logic [31:0] error_count;
  logic        len_valid;
  logic [15:0] len_value;
  logic        activity;

  int          checks;
  int          errors;
  logic [8:0]  q[$];
  logic [15:0] lens[$];

  xgmii_rx_monitor #(.MIN_LEN(64), .ACT_BITS(4)) dut (
    .clk156     (clk156),
    .sys_rst_n  (sys_rst_n),
    .xgmii_rxd  (xgmii_rxd),
    .xgmii_rxc  (xgmii_rxc),
    .xgmii_txd  (xgmii_txd),
    .xgmii_txc  (xgmii_txc),
    .stats_clear(stats_clear),
    .frame_count(frame_count),
    .error_count(error_count),
    .len_valid  (len_valid),
    .len_value  (len_value),
    .activity   (activity)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd = d;
    xgmii_rxc = c;
    @(posedge clk156);
    #1;
    chk("txd_pass", xgmii_txd, d);
    chk("txc_pass", 64'(xgmii_txc), 64'(c));
    if (len_valid === 1'b1) lens.push_back(len_value);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) cyc(IDLE_W, 8'hFF);
  endtask

  // Start + 6 preamble + SFD, len data octets, optional terminate.
  // err_idx >= 0 replaces that octet (frame-relative) with a control 0xFE.
  task automatic push_frame(input int len, input int err_idx, input bit term);
    int base;
    base = q.size();
    q.push_back({1'b1, 8'hFB});
    for (int i = 0; i < 6; i++) q.push_back({1'b0, 8'h55});
    q.push_back({1'b0, 8'hD5});
    for (int i = 0; i < len; i++) q.push_back({1'b0, 8'(i * 7 + 3)});
    if (term) q.push_back({1'b1, 8'hFD});
    if (err_idx >= 0) q[base + err_idx] = {1'b1, 8'hFE};
  endtask

  task automatic send_q(input int max_words, input bit clr_term);
    logic [63:0] d;
    logic [7:0]  c;
    bit          has_term;
    while ((q.size() % 8) != 0) q.push_back({1'b1, 8'h07});
    for (int w = 0; (w < max_words) && (w * 8 < q.size()); w++) begin
      has_term = 1'b0;
      for (int n = 0; n < 8; n++) begin
        d[8*n +: 8] = q[w*8 + n][7:0];
        c[n]        = q[w*8 + n][8];
        if (q[w*8 + n] == {1'b1, 8'hFD}) has_term = 1'b1;
      end
      stats_clear = clr_term && has_term;
      cyc(d, c);
    end
    stats_clear = 1'b0;
    q.delete();
  endtask

  task automatic do_clear();
    stats_clear = 1'b1;
    cyc(IDLE_W, 8'hFF);
    stats_clear = 1'b0;
    lens.delete();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    sys_rst_n   = 1'b0;
    stats_clear = 1'b0;
    xgmii_rxd   = 64'h1122334455667788;
    xgmii_rxc   = 8'h00;
    repeat (3) @(posedge clk156);
    #1;
    chk("rst_txd", xgmii_txd, IDLE_W);
    chk("rst_txc", 64'(xgmii_txc), 64'hFF);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_error_count", 64'(error_count), 64'd0);
    chk("rst_len_valid", 64'(len_valid), 64'd0);
    chk("rst_len_value", 64'(len_value), 64'd0);
    chk("rst_activity", 64'(activity), 64'd0);
    xgmii_rxd = IDLE_W;
    xgmii_rxc = 8'hFF;
    sys_rst_n = 1'b1;
    idles(5);
    chk("idle_no_pulse", 64'(lens.size()), 64'd0);

    // 64-octet good frame
    push_frame(64, -1, 1);
    send_q(100, 0);
    idles(2);
    chk("good64_pulses", 64'(lens.size()), 64'd1);
    if (lens.size() > 0) chk("good64_len", 64'(lens[0]), 64'd64);
    chk("good64_frame_count", 64'(frame_count), 64'd1);
    chk("good64_error_count", 64'(error_count), 64'd0);
    chk("good64_activity", 64'(activity), 64'd1);
    lens.delete();

    // Runts: 60 and the MIN_LEN-1 boundary
    push_frame(60, -1, 1);
    send_q(100, 0);
    idles(1);
    chk("runt60_len", (lens.size() == 1) ? 64'(lens[0]) : 64'hDEAD, 64'd60);
    chk("runt60_error_count", 64'(error_count), 64'd1);
    chk("runt60_frame_count", 64'(frame_count), 64'd1);
    lens.delete();
    push_frame(63, -1, 1);
    send_q(100, 0);
    idles(1);
    chk("runt63_len", (lens.size() == 1) ? 64'(lens[0]) : 64'hDEAD, 64'd63);
    chk("runt63_error_count", 64'(error_count), 64'd2);
    chk("runt63_frame_count", 64'(frame_count), 64'd1);

    do_clear();
    chk("clear_frame_count", 64'(frame_count), 64'd0);
    chk("clear_error_count", 64'(error_count), 64'd0);

    // 100-octet frame with 0xFE in lane 3 of its third word
    push_frame(100, 19, 1);
    send_q(100, 0);
    idles(1);
    chk("fe_len", (lens.size() == 1) ? 64'(lens[0]) : 64'hDEAD, 64'd99);
    chk("fe_error_count", 64'(error_count), 64'd1);
    chk("fe_frame_count", 64'(frame_count), 64'd0);
    do_clear();

    // Terminate lane 2 then start lane 4 in the same word
    push_frame(66, -1, 1);
    q.push_back({1'b1, 8'h07});
    push_frame(64, -1, 1);
    send_q(100, 0);
    idles(1);
    chk("b2b_pulses", 64'(lens.size()), 64'd2);
    if (lens.size() == 2) begin
      chk("b2b_len0", 64'(lens[0]), 64'd66);
      chk("b2b_len1", 64'(lens[1]), 64'd64);
    end
    chk("b2b_frame_count", 64'(frame_count), 64'd2);
    chk("b2b_error_count", 64'(error_count), 64'd0);
    do_clear();

    // Start in lane 4 while a frame is open
    push_frame(20, -1, 0);
    push_frame(64, -1, 1);
    send_q(100, 0);
    idles(1);
    chk("restart_pulses", 64'(lens.size()), 64'd2);
    if (lens.size() == 2) begin
      chk("restart_len0", 64'(lens[0]), 64'd20);
      chk("restart_len1", 64'(lens[1]), 64'd64);
    end
    chk("restart_error_count", 64'(error_count), 64'd1);
    chk("restart_frame_count", 64'(frame_count), 64'd1);
    lens.delete();

    // stats_clear coincident with a good close
    push_frame(64, -1, 1);
    send_q(100, 1);
    chk("clr_win_frame_count", 64'(frame_count), 64'd0);
    chk("clr_win_error_count", 64'(error_count), 64'd0);
    chk("clr_win_len_valid", 64'(len_valid), 64'd1);
    idles(1);
    lens.delete();

    // Activity decays after the stretch expires
    idles(20);
    chk("activity_decay", 64'(activity), 64'd0);

    // Reset mid-frame
    push_frame(64, -1, 1);
    send_q(100, 0);
    idles(1);
    chk("pre_rst_frame_count", 64'(frame_count), 64'd1);
    push_frame(64, -1, 1);
    send_q(4, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_txd", xgmii_txd, IDLE_W);
    chk("midrst_txc", 64'(xgmii_txc), 64'hFF);
    chk("midrst_frame_count", 64'(frame_count), 64'd0);
    chk("midrst_error_count", 64'(error_count), 64'd0);
    chk("midrst_len_valid", 64'(len_valid), 64'd0);
    xgmii_rxd = IDLE_W;
    xgmii_rxc = 8'hFF;
    repeat (2) @(posedge clk156);
    #1;
    sys_rst_n = 1'b1;
    lens.delete();
    idles(4);
    chk("postrst_no_pulse", 64'(lens.size()), 64'd0);
    chk("postrst_error_count", 64'(error_count), 64'd0);
    push_frame(64, -1, 1);
    send_q(100, 0);
    idles(1);
    chk("postrst_len", (lens.size() == 1) ? 64'(lens[0]) : 64'hDEAD, 64'd64);
    chk("postrst_frame_count", 64'(frame_count), 64'd1);
    chk("postrst_error_count2", 64'(error_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
